// File: rtl/vga_fb_arbiter_if.sv
// Host access bus for the framebuffer arbiter: request/acknowledge handshake
// with word address, write data and read data.
interface vga_fb_arbiter_if #(
    parameter int ADDR_W = 15
);
    logic              host_req;
    logic              host_we;
    logic [ADDR_W-1:0] host_addr;
    logic [15:0]       host_wdata;
    logic              host_ack;
    logic [15:0]       host_rdata;

    modport master (
        output host_req,
        output host_we,
        output host_addr,
        output host_wdata,
        input  host_ack,
        input  host_rdata
    );

    modport slave (
        input  host_req,
        input  host_we,
        input  host_addr,
        input  host_wdata,
        output host_ack,
        output host_rdata
    );
endinterface

// File: rtl/vga_fb_arbiter.sv
// Single-port framebuffer arbiter: prefetches the next display line into a
// double-banked line buffer and fits host accesses into the idle gaps.
module vga_fb_arbiter #(
    parameter int H_DISPLAY      = 640,
    parameter int V_DISPLAY      = 480,
    parameter int V_TOTAL        = 525,
    parameter int WORDS_PER_LINE = 40,
    parameter int ADDR_W         = 15
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [9:0]        h_count,
    input  logic [9:0]        v_count,
    vga_fb_arbiter_if.slave   host,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [15:0]       mem_wdata,
    input  logic [15:0]       mem_rdata,
    output logic              lb_we,
    output logic [5:0]        lb_waddr,
    output logic [15:0]       lb_wdata,
    output logic              lb_bank,
    output logic              underrun
);

    typedef enum logic [1:0] {IDLE, FETCH, DRAIN, HOST} state_t;

    localparam logic [9:0]        H_DISP_L = 10'(H_DISPLAY);
    localparam logic [9:0]        V_DISP_L = 10'(V_DISPLAY);
    localparam logic [9:0]        V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [5:0]        LAST_IDX = 6'(WORDS_PER_LINE - 1);
    localparam logic [ADDR_W-1:0] WPL_A    = ADDR_W'(WORDS_PER_LINE);

    state_t            state_q, state_d;
    logic [5:0]        idx_q, idx_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic              fetch_pending_q, fetch_pending_d;
    logic              host_phase_q, host_phase_d;
    logic              lb_bank_q, lb_bank_d;
    logic              underrun_q, underrun_d;
    logic [15:0]       host_rdata_q, host_rdata_d;
    logic              host_ack_q, host_ack_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic              mem_we_q, mem_we_d;
    logic [15:0]       mem_wdata_q, mem_wdata_d;
    logic              lb_we_q, lb_we_d;
    logic [5:0]        lb_waddr_q, lb_waddr_d;

    logic [9:0]        target;
    logic              trigger;
    logic [ADDR_W-1:0] trig_base;

    assign target    = (v_count == V_LAST) ? 10'd0 : v_count + 10'd1;
    assign trigger   = (h_count == H_DISP_L) && (target < V_DISP_L);
    assign trig_base = ADDR_W'(target) * WPL_A;

    // Next-state logic; bus strobes are derived from the next state so that
    // they come straight out of flops in the cycle the state is entered.
    always_comb begin
        state_d         = state_q;
        idx_d           = idx_q;
        base_d          = base_q;
        fetch_pending_d = fetch_pending_q;
        host_phase_d    = 1'b0;
        lb_bank_d       = lb_bank_q;
        host_rdata_d    = host_rdata_q;
        underrun_d      = underrun_q |
                          (((state_q == FETCH) || (state_q == DRAIN)) && (h_count == 10'd0));

        case (state_q)
            IDLE: begin
                if (trigger) begin
                    state_d = FETCH;
                    idx_d   = 6'd0;
                    base_d  = trig_base;
                end else if (fetch_pending_q) begin
                    state_d         = FETCH;
                    idx_d           = 6'd0;
                    fetch_pending_d = 1'b0;
                end else if (host.host_req) begin
                    state_d = HOST;
                end
            end
            HOST: begin
                if (trigger) begin
                    fetch_pending_d = 1'b1;
                    base_d          = trig_base;
                end
                if (!host_phase_q) begin
                    host_phase_d = 1'b1;
                end else begin
                    if (!host.host_we) begin
                        host_rdata_d = mem_rdata;
                    end
                    // A trigger seen at any point of the access starts the fetch immediately after it.
                    if (trigger || fetch_pending_q) begin
                        state_d         = FETCH;
                        idx_d           = 6'd0;
                        fetch_pending_d = 1'b0;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            FETCH: begin
                if (idx_q == LAST_IDX) begin
                    state_d = DRAIN;
                end else begin
                    idx_d = idx_q + 6'd1;
                end
            end
            DRAIN: begin
                state_d   = IDLE;
                idx_d     = 6'd0;
                lb_bank_d = ~lb_bank_q;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        mem_addr_d  = '0;
        mem_we_d    = 1'b0;
        mem_wdata_d = 16'd0;
        if (state_d == FETCH) begin
            mem_addr_d = base_d + ADDR_W'(idx_d);
        end else if ((state_d == HOST) && !host_phase_d) begin
            mem_addr_d  = host.host_addr;
            mem_we_d    = host.host_we;
            mem_wdata_d = host.host_we ? host.host_wdata : 16'd0;
        end
        host_ack_d = (state_d == HOST) && host_phase_d;

        // Read data for a fetch arrives one cycle after its address.
        lb_we_d    = (state_q == FETCH);
        lb_waddr_d = (state_q == FETCH) ? idx_q : 6'd0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q         <= IDLE;
            idx_q           <= 6'd0;
            base_q          <= '0;
            fetch_pending_q <= 1'b0;
            host_phase_q    <= 1'b0;
            lb_bank_q       <= 1'b0;
            underrun_q      <= 1'b0;
            host_rdata_q    <= 16'd0;
            host_ack_q      <= 1'b0;
            mem_addr_q      <= '0;
            mem_we_q        <= 1'b0;
            mem_wdata_q     <= 16'd0;
            lb_we_q         <= 1'b0;
            lb_waddr_q      <= 6'd0;
        end else begin
            state_q         <= state_d;
            idx_q           <= idx_d;
            base_q          <= base_d;
            fetch_pending_q <= fetch_pending_d;
            host_phase_q    <= host_phase_d;
            lb_bank_q       <= lb_bank_d;
            underrun_q      <= underrun_d;
            host_rdata_q    <= host_rdata_d;
            host_ack_q      <= host_ack_d;
            mem_addr_q      <= mem_addr_d;
            mem_we_q        <= mem_we_d;
            mem_wdata_q     <= mem_wdata_d;
            lb_we_q         <= lb_we_d;
            lb_waddr_q      <= lb_waddr_d;
        end
    end

    assign mem_addr        = mem_addr_q;
    assign mem_we          = mem_we_q;
    assign mem_wdata       = mem_wdata_q;
    assign lb_we           = lb_we_q;
    assign lb_waddr        = lb_waddr_q;
    assign lb_wdata        = lb_we_q ? mem_rdata : 16'd0;
    assign lb_bank         = lb_bank_q;
    assign underrun        = underrun_q;
    assign host.host_ack   = host_ack_q;
    // Read data is forwarded straight from memory in the acknowledge cycle, then held.
    assign host.host_rdata = (host_ack_q && !host.host_we) ? mem_rdata : host_rdata_q;

endmodule

// File: tb/tb_vga_fb_arbiter.sv
// Directed bench for vga_fb_arbiter: line fetches, host accesses, arbitration
// against the fetch trigger, reset abort and the underrun flag.
module tb_vga_fb_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic [9:0]  h_count;
    logic [9:0]  v_count;
    logic [14:0] mem_addr;
    logic        mem_we;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata = 16'd0;
    logic        lb_we;
    logic [5:0]  lb_waddr;
    logic [15:0] lb_wdata;
    logic        lb_bank;
    logic        underrun;

    int   n_compared   = 0;
    int   n_mismatched = 0;
    logic exp_bank     = 1'b0;

    vga_fb_arbiter_if #(.ADDR_W(15)) hif ();

    vga_fb_arbiter dut (
        .clk      (clk),
        .reset    (reset),
        .h_count  (h_count),
        .v_count  (v_count),
        .host     (hif),
        .mem_addr (mem_addr),
        .mem_we   (mem_we),
        .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata),
        .lb_we    (lb_we),
        .lb_waddr (lb_waddr),
        .lb_wdata (lb_wdata),
        .lb_bank  (lb_bank),
        .underrun (underrun)
    );

    always #5 clk = ~clk;

    // Framebuffer contents: a fixed address pattern plus one written word.
    function automatic logic [15:0] pat(input logic [14:0] a);
        return {1'b0, a} ^ 16'hC3A5;
    endfunction

    logic        wr_valid = 1'b0;
    logic [14:0] wr_addr  = 15'd0;
    logic [15:0] wr_data  = 16'd0;

    always @(posedge clk) begin
        if (reset) begin
            wr_valid <= 1'b0;
        end else if (mem_we) begin
            wr_valid <= 1'b1;
            wr_addr  <= mem_addr;
            wr_data  <= mem_wdata;
        end
        mem_rdata <= (wr_valid && (wr_addr == mem_addr)) ? wr_data : pat(mem_addr);
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_compared++;
        if (got !== exp) begin
            n_mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic applyStimulus(input logic [9:0] h, input logic [9:0] v);
        h_count = h;
        v_count = v;
        @(posedge clk);
        #1;
    endtask

    // Called right after the edge that enters FETCH with index 0.
    task automatic expectFetch(input string tag, input int base);
        for (int k = 0; k < 40; k++) begin
            checkOutput({tag, "_addr"}, 32'(mem_addr), 32'(base + k));
            checkOutput({tag, "_mwe"}, 32'(mem_we), 32'd0);
            if (k > 0) begin
                checkOutput({tag, "_lbwe"}, 32'(lb_we), 32'd1);
                checkOutput({tag, "_lbaddr"}, 32'(lb_waddr), 32'(k - 1));
                checkOutput({tag, "_lbdata"}, 32'(lb_wdata), 32'(pat(15'(base + k - 1))));
            end else begin
                checkOutput({tag, "_lbwe0"}, 32'(lb_we), 32'd0);
            end
            checkOutput({tag, "_bank"}, 32'(lb_bank), 32'(exp_bank));
            applyStimulus(h_count + 10'd1, v_count);
        end
        checkOutput({tag, "_drain_lbwe"}, 32'(lb_we), 32'd1);
        checkOutput({tag, "_drain_lbaddr"}, 32'(lb_waddr), 32'd39);
        checkOutput({tag, "_drain_lbdata"}, 32'(lb_wdata), 32'(pat(15'(base + 39))));
        checkOutput({tag, "_drain_addr"}, 32'(mem_addr), 32'd0);
        checkOutput({tag, "_drain_bank"}, 32'(lb_bank), 32'(exp_bank));
        applyStimulus(h_count + 10'd1, v_count);
        exp_bank = ~exp_bank;
        checkOutput({tag, "_toggle"}, 32'(lb_bank), 32'(exp_bank));
        checkOutput({tag, "_idle_lbwe"}, 32'(lb_we), 32'd0);
        checkOutput({tag, "_idle_addr"}, 32'(mem_addr), 32'd0);
    endtask

    initial begin
        reset          = 1'b1;
        h_count        = 10'd0;
        v_count        = 10'd0;
        hif.host_req   = 1'b0;
        hif.host_we    = 1'b0;
        hif.host_addr  = 15'd0;
        hif.host_wdata = 16'd0;
        applyStimulus(10'd0, 10'd0);
        applyStimulus(10'd0, 10'd0);

        checkOutput("rst_mem_addr", 32'(mem_addr), 32'd0);
        checkOutput("rst_mem_we", 32'(mem_we), 32'd0);
        checkOutput("rst_lb_we", 32'(lb_we), 32'd0);
        checkOutput("rst_lb_bank", 32'(lb_bank), 32'd0);
        checkOutput("rst_underrun", 32'(underrun), 32'd0);
        checkOutput("rst_ack", 32'(hif.host_ack), 32'd0);
        checkOutput("rst_rdata", 32'(hif.host_rdata), 32'd0);

        // Line 11 fetch while displaying line 10
        reset = 1'b0;
        applyStimulus(10'd638, 10'd10);
        applyStimulus(10'd639, 10'd10);
        checkOutput("pre_trig_addr", 32'(mem_addr), 32'd0);
        applyStimulus(10'd640, 10'd10);
        expectFetch("l11", 440);

        // Frame wrap and the bottom-of-screen boundary
        applyStimulus(10'd639, 10'd524);
        applyStimulus(10'd640, 10'd524);
        expectFetch("l0", 0);
        applyStimulus(10'd640, 10'd479);
        checkOutput("nofetch479_addr", 32'(mem_addr), 32'd0);
        applyStimulus(10'd641, 10'd479);
        checkOutput("nofetch479_addr2", 32'(mem_addr), 32'd0);
        checkOutput("nofetch479_lbwe", 32'(lb_we), 32'd0);
        applyStimulus(10'd640, 10'd500);
        checkOutput("nofetch500_addr", 32'(mem_addr), 32'd0);
        applyStimulus(10'd641, 10'd500);
        checkOutput("nofetch500_lbwe", 32'(lb_we), 32'd0);
        checkOutput("nofetch_bank", 32'(lb_bank), 32'(exp_bank));

        // Reset in the middle of a fetch, then a clean refetch
        applyStimulus(10'd640, 10'd10);
        for (int k = 0; k < 20; k++) applyStimulus(h_count + 10'd1, 10'd10);
        checkOutput("pre_reset_addr", 32'(mem_addr), 32'd460);
        reset = 1'b1;
        applyStimulus(h_count + 10'd1, 10'd10);
        checkOutput("abort_mem_addr", 32'(mem_addr), 32'd0);
        checkOutput("abort_mem_we", 32'(mem_we), 32'd0);
        checkOutput("abort_lb_we", 32'(lb_we), 32'd0);
        checkOutput("abort_bank", 32'(lb_bank), 32'd0);
        exp_bank = 1'b0;
        reset = 1'b0;
        applyStimulus(10'd100, 10'd10);
        checkOutput("abort_idle_addr", 32'(mem_addr), 32'd0);
        applyStimulus(10'd640, 10'd10);
        expectFetch("refetch", 440);

        // Host write then reads, including an immediate re-grant
        hif.host_req   = 1'b1;
        hif.host_we    = 1'b1;
        hif.host_addr  = 15'h0123;
        hif.host_wdata = 16'hBEEF;
        applyStimulus(10'd100, 10'd10);
        checkOutput("wr_c1_addr", 32'(mem_addr), 32'h0123);
        checkOutput("wr_c1_we", 32'(mem_we), 32'd1);
        checkOutput("wr_c1_wdata", 32'(mem_wdata), 32'hBEEF);
        checkOutput("wr_c1_ack", 32'(hif.host_ack), 32'd0);
        applyStimulus(10'd101, 10'd10);
        checkOutput("wr_c2_ack", 32'(hif.host_ack), 32'd1);
        checkOutput("wr_c2_we", 32'(mem_we), 32'd0);
        checkOutput("wr_c2_addr", 32'(mem_addr), 32'd0);
        hif.host_req = 1'b0;
        applyStimulus(10'd102, 10'd10);
        checkOutput("wr_after_ack", 32'(hif.host_ack), 32'd0);
        hif.host_req = 1'b1;
        hif.host_we  = 1'b0;
        applyStimulus(10'd103, 10'd10);
        checkOutput("rd_c1_addr", 32'(mem_addr), 32'h0123);
        checkOutput("rd_c1_we", 32'(mem_we), 32'd0);
        checkOutput("rd_c1_ack", 32'(hif.host_ack), 32'd0);
        applyStimulus(10'd104, 10'd10);
        checkOutput("rd_c2_ack", 32'(hif.host_ack), 32'd1);
        checkOutput("rd_c2_rdata", 32'(hif.host_rdata), 32'hBEEF);
        hif.host_addr = 15'h0200;
        applyStimulus(10'd105, 10'd10);
        checkOutput("regrant_gap_ack", 32'(hif.host_ack), 32'd0);
        checkOutput("regrant_gap_addr", 32'(mem_addr), 32'd0);
        checkOutput("rdata_hold", 32'(hif.host_rdata), 32'hBEEF);
        applyStimulus(10'd106, 10'd10);
        checkOutput("regrant_addr", 32'(mem_addr), 32'h0200);
        applyStimulus(10'd107, 10'd10);
        checkOutput("regrant_ack", 32'(hif.host_ack), 32'd1);
        checkOutput("regrant_rdata", 32'(hif.host_rdata), 32'(pat(15'h0200)));
        hif.host_req = 1'b0;
        applyStimulus(10'd108, 10'd10);
        checkOutput("regrant_done_ack", 32'(hif.host_ack), 32'd0);
        checkOutput("regrant_rdata_hold", 32'(hif.host_rdata), 32'(pat(15'h0200)));

        // Host granted one cycle before the trigger; fetch follows the access
        applyStimulus(10'd638, 10'd20);
        hif.host_req  = 1'b1;
        hif.host_we   = 1'b0;
        hif.host_addr = 15'h0050;
        applyStimulus(10'd639, 10'd20);
        checkOutput("pend_c1_addr", 32'(mem_addr), 32'h0050);
        applyStimulus(10'd640, 10'd20);
        checkOutput("pend_c2_ack", 32'(hif.host_ack), 32'd1);
        checkOutput("pend_c2_rdata", 32'(hif.host_rdata), 32'(pat(15'h0050)));
        hif.host_req = 1'b0;
        applyStimulus(10'd641, 10'd20);
        expectFetch("pend", 840);
        checkOutput("pend_underrun", 32'(underrun), 32'd0);

        // Host request held across a trigger in IDLE: fetch first
        hif.host_req   = 1'b1;
        hif.host_we    = 1'b1;
        hif.host_addr  = 15'h0300;
        hif.host_wdata = 16'h1234;
        applyStimulus(10'd640, 10'd40);
        expectFetch("held", 1640);
        checkOutput("held_no_ack", 32'(hif.host_ack), 32'd0);
        applyStimulus(h_count + 10'd1, 10'd40);
        checkOutput("held_c1_addr", 32'(mem_addr), 32'h0300);
        checkOutput("held_c1_we", 32'(mem_we), 32'd1);
        checkOutput("held_c1_wdata", 32'(mem_wdata), 32'h1234);
        applyStimulus(h_count + 10'd1, 10'd40);
        checkOutput("held_c2_ack", 32'(hif.host_ack), 32'd1);
        hif.host_req = 1'b0;
        applyStimulus(h_count + 10'd1, 10'd40);
        checkOutput("held_done_ack", 32'(hif.host_ack), 32'd0);

        // Fetch still running when the next line starts
        applyStimulus(10'd639, 10'd50);
        applyStimulus(10'd640, 10'd50);
        for (int k = 0; k < 5; k++) applyStimulus(h_count + 10'd1, 10'd50);
        checkOutput("late_pre_underrun", 32'(underrun), 32'd0);
        applyStimulus(10'd0, 10'd50);
        checkOutput("late_underrun_set", 32'(underrun), 32'd1);
        checkOutput("late_fetch_continues", 32'(mem_addr), 32'(2040 + 6));
        for (int k = 0; k < 35; k++) applyStimulus(h_count + 10'd1, 10'd50);
        exp_bank = ~exp_bank;
        checkOutput("late_toggle", 32'(lb_bank), 32'(exp_bank));
        checkOutput("late_idle_lbwe", 32'(lb_we), 32'd0);
        checkOutput("late_underrun_sticky", 32'(underrun), 32'd1);
        reset = 1'b1;
        applyStimulus(h_count + 10'd1, 10'd50);
        checkOutput("final_rst_underrun", 32'(underrun), 32'd0);
        checkOutput("final_rst_bank", 32'(lb_bank), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
